// File: rtl/irq_frontend.sv
// External-interrupt front end: synchronise, polarity-correct, glitch-filter and
// qualify request lines (level or latched edge) for the vectored interrupt controller.
module irq_frontend #(
  parameter int unsigned N_LINES     = 31,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FILT_LEN    = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_LINES-1:0] i_irq,
  input  logic               i_cfg_we,
  input  logic [1:0]         i_cfg_sel,
  input  logic [N_LINES-1:0] i_cfg_wdata,
  output logic [N_LINES-1:0] o_cfg_rdata,
  input  logic               i_ack,
  input  logic [4:0]         i_ack_id,
  output logic [N_LINES-1:0] o_ext
);

  localparam int unsigned CNT_W = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FILT_LEN - 1);

  localparam logic [1:0] SEL_EN   = 2'd0;
  localparam logic [1:0] SEL_MODE = 2'd1;
  localparam logic [1:0] SEL_POL  = 2'd2;
  localparam logic [1:0] SEL_PEND = 2'd3;

  logic [N_LINES-1:0] sync_q [SYNC_STAGES];
  logic [N_LINES-1:0] en_q, mode_q, pol_q, pend_q, f_q;
  logic [CNT_W-1:0]   cnt_q [N_LINES];

  logic [N_LINES-1:0] s_c, f_n, rise_c, mode_n, ack_c, w1c_c, pend_n;
  logic [CNT_W-1:0]   cnt_n [N_LINES];

  // Multi-stage synchroniser per line
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
    end else begin
      sync_q[0] <= i_irq;
      for (int unsigned k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
    end
  end

  assign s_c = sync_q[SYNC_STAGES-1] ^ pol_q;

  // Glitch filter: a new level must disagree with f for FILT_LEN evaluations in a row
  always_comb begin
    f_n    = f_q;
    rise_c = '0;
    for (int unsigned i = 0; i < N_LINES; i++) begin
      cnt_n[i] = '0;
      if (s_c[i] != f_q[i]) begin
        if (cnt_q[i] == CNT_MAX) begin
          f_n[i]    = s_c[i];
          rise_c[i] = s_c[i];
        end else begin
          cnt_n[i] = cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  // Pending: set beats clear; forced low for level-mode lines
  always_comb begin
    for (int unsigned i = 0; i < N_LINES; i++) begin
      ack_c[i] = i_ack && (i_ack_id == 5'(i));
    end
    w1c_c  = (i_cfg_we && (i_cfg_sel == SEL_PEND)) ? i_cfg_wdata : '0;
    mode_n = (i_cfg_we && (i_cfg_sel == SEL_MODE)) ? i_cfg_wdata : mode_q;
    pend_n = ((pend_q & ~(ack_c | w1c_c)) | (rise_c & en_q & mode_q)) & mode_n;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      en_q   <= '0;
      mode_q <= '0;
      pol_q  <= '0;
      pend_q <= '0;
      f_q    <= '0;
      o_ext  <= '0;
      for (int unsigned i = 0; i < N_LINES; i++) cnt_q[i] <= '0;
    end else begin
      if (i_cfg_we && (i_cfg_sel == SEL_EN))  en_q  <= i_cfg_wdata;
      if (i_cfg_we && (i_cfg_sel == SEL_POL)) pol_q <= i_cfg_wdata;
      mode_q <= mode_n;
      pend_q <= pend_n;
      f_q    <= f_n;
      for (int unsigned i = 0; i < N_LINES; i++) cnt_q[i] <= cnt_n[i];
      o_ext  <= en_q & ((mode_q & pend_q) | (~mode_q & f_q));
    end
  end

  always_comb begin
    o_cfg_rdata = '0;
    case (i_cfg_sel)
      SEL_EN:   o_cfg_rdata = en_q;
      SEL_MODE: o_cfg_rdata = mode_q;
      SEL_POL:  o_cfg_rdata = pol_q;
      SEL_PEND: o_cfg_rdata = pend_q;
      default:  o_cfg_rdata = '0;
    endcase
  end

endmodule

// File: tb/tb_irq_frontend.sv
// Bench for irq_frontend: directed vector table, hand-written corner sequences,
// and a randomized run against a cycle-level reference model.
module tb_irq_frontend;

  localparam int unsigned N    = 31;
  localparam int unsigned SYNC = 2;
  localparam int unsigned FILT = 2;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [N-1:0] i_irq = '0;
  logic         i_cfg_we = 1'b0;
  logic [1:0]   i_cfg_sel = 2'd0;
  logic [N-1:0] i_cfg_wdata = '0;
  logic [N-1:0] o_cfg_rdata;
  logic         i_ack = 1'b0;
  logic [4:0]   i_ack_id = 5'd0;
  logic [N-1:0] o_ext;

  irq_frontend #(.N_LINES(N), .SYNC_STAGES(SYNC), .FILT_LEN(FILT)) dut (
    .clk(clk), .rst(rst), .i_irq(i_irq), .i_cfg_we(i_cfg_we), .i_cfg_sel(i_cfg_sel),
    .i_cfg_wdata(i_cfg_wdata), .o_cfg_rdata(o_cfg_rdata), .i_ack(i_ack),
    .i_ack_id(i_ack_id), .o_ext(o_ext)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Reference model state: sampled-input history, registers, filter run lengths
  logic [N-1:0] m_hist [SYNC];
  logic [N-1:0] m_en, m_mode, m_pol, m_pend, m_f, m_ext;
  int           m_run [N];

  task automatic model_reset();
    for (int k = 0; k < int'(SYNC); k++) m_hist[k] = '0;
    m_en = '0; m_mode = '0; m_pol = '0; m_pend = '0; m_f = '0; m_ext = '0;
    for (int i = 0; i < int'(N); i++) m_run[i] = 0;
  endtask

  function automatic logic [N-1:0] m_rd(input logic [1:0] sel);
    case (sel)
      2'd0:    return m_en;
      2'd1:    return m_mode;
      2'd2:    return m_pol;
      default: return m_pend;
    endcase
  endfunction

  // Advance the model by one clock edge using the inputs currently applied
  task automatic model_tick();
    logic [N-1:0] s, nf, rise, ackv, clr, nen, nmode, npol, npend, next_ext;
    int id;
    s    = m_hist[SYNC-1] ^ m_pol;
    nf   = m_f;
    rise = '0;
    for (int i = 0; i < int'(N); i++) begin
      if (s[i] == m_f[i]) m_run[i] = 0;
      else if (m_run[i] + 1 >= int'(FILT)) begin
        nf[i] = s[i]; rise[i] = s[i]; m_run[i] = 0;
      end else m_run[i] = m_run[i] + 1;
    end
    next_ext = m_en & (m_mode ? m_pend : m_f) | '0;
    for (int i = 0; i < int'(N); i++) next_ext[i] = m_en[i] && (m_mode[i] ? m_pend[i] : m_f[i]);
    ackv = '0;
    id = int'(i_ack_id);
    if (i_ack && id < int'(N)) ackv[id] = 1'b1;
    nen   = (i_cfg_we && i_cfg_sel == 2'd0) ? i_cfg_wdata : m_en;
    nmode = (i_cfg_we && i_cfg_sel == 2'd1) ? i_cfg_wdata : m_mode;
    npol  = (i_cfg_we && i_cfg_sel == 2'd2) ? i_cfg_wdata : m_pol;
    clr   = ackv | ((i_cfg_we && i_cfg_sel == 2'd3) ? i_cfg_wdata : '0);
    npend = ((m_pend & ~clr) | (rise & m_en & m_mode)) & nmode;
    for (int k = int'(SYNC) - 1; k > 0; k--) m_hist[k] = m_hist[k-1];
    m_hist[0] = i_irq;
    m_en = nen; m_mode = nmode; m_pol = npol; m_pend = npend; m_f = nf; m_ext = next_ext;
  endtask

  task automatic step();
    model_tick();
    @(posedge clk);
    #1;
    check("ext_vs_model", 32'(o_ext), 32'(m_ext));
  endtask

  task automatic cfg_write(input logic [1:0] sel, input logic [N-1:0] data);
    i_cfg_we = 1'b1; i_cfg_sel = sel; i_cfg_wdata = data;
    step();
    i_cfg_we = 1'b0;
  endtask

  task automatic wait_bit(input string name, input int idx, input logic val, input int budget);
    int n = 0;
    while (o_ext[idx] !== val && n < budget) begin
      step();
      n++;
    end
    check(name, 32'(o_ext[idx]), 32'(val));
  endtask

  typedef struct {
    logic         we;
    logic [1:0]   sel;
    logic [N-1:0] wdata;
    logic [N-1:0] irq;
    logic [N-1:0] exp_ext;
  } vec_t;

  function automatic vec_t v(input logic we, input logic [1:0] sel, input logic [N-1:0] wdata,
                             input logic [N-1:0] irq, input logic [N-1:0] exp_ext);
    vec_t r;
    r.we = we; r.sel = sel; r.wdata = wdata; r.irq = irq; r.exp_ext = exp_ext;
    return r;
  endfunction

  localparam logic [N-1:0] EN = 31'h2AD;  // lines 0,2,3,5,7,9
  localparam logic [N-1:0] MD = 31'h284;  // edge lines 2,7,9
  localparam logic [N-1:0] PL = 31'h020;  // line 5 active-low

  vec_t tbl [17];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // Level line 0 rise/fall latency, then 1-cycle glitch on line 3
    tbl[0]  = v(1'b1, 2'd0, 31'h9, 31'h0, 31'h0);
    tbl[1]  = v(1'b0, 2'd0, 31'h0, 31'h1, 31'h0);
    tbl[2]  = v(1'b0, 2'd0, 31'h0, 31'h1, 31'h0);
    tbl[3]  = v(1'b0, 2'd0, 31'h0, 31'h1, 31'h0);
    tbl[4]  = v(1'b0, 2'd0, 31'h0, 31'h1, 31'h0);
    tbl[5]  = v(1'b0, 2'd0, 31'h0, 31'h1, 31'h1);
    tbl[6]  = v(1'b0, 2'd0, 31'h0, 31'h0, 31'h1);
    tbl[7]  = v(1'b0, 2'd0, 31'h0, 31'h0, 31'h1);
    tbl[8]  = v(1'b0, 2'd0, 31'h0, 31'h0, 31'h1);
    tbl[9]  = v(1'b0, 2'd0, 31'h0, 31'h0, 31'h1);
    tbl[10] = v(1'b0, 2'd0, 31'h0, 31'h0, 31'h0);
    tbl[11] = v(1'b0, 2'd0, 31'h0, 31'h8, 31'h0);
    for (int r = 12; r < 17; r++) tbl[r] = v(1'b0, 2'd0, 31'h0, 31'h0, 31'h0);

    // Reset held: inputs toggle, nothing propagates
    model_reset();
    for (int c = 0; c < 4; c++) begin
      i_irq = N'($urandom);
      @(posedge clk);
      #1;
      check("rst_ext", 32'(o_ext), 32'h0);
    end
    for (int s = 0; s < 4; s++) begin
      i_cfg_sel = 2'(s);
      #1;
      check($sformatf("rst_rd%0d", s), 32'(o_cfg_rdata), 32'h0);
    end
    i_irq = '0;
    rst = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      check("post_rst_ext", 32'(o_ext), 32'h0);
    end

    for (int r = 0; r < 17; r++) begin
      i_cfg_we = tbl[r].we; i_cfg_sel = tbl[r].sel; i_cfg_wdata = tbl[r].wdata;
      i_irq = tbl[r].irq;
      step();
      check($sformatf("vec%0d", r), 32'(o_ext), 32'(tbl[r].exp_ext));
    end
    i_cfg_we = 1'b0;

    cfg_write(2'd0, EN);
    cfg_write(2'd1, MD);
    cfg_write(2'd2, PL);
    i_cfg_sel = 2'd0; #1; check("rd_en", 32'(o_cfg_rdata), 32'(EN));
    i_cfg_sel = 2'd1; #1; check("rd_mode", 32'(o_cfg_rdata), 32'(MD));
    i_cfg_sel = 2'd2; #1; check("rd_pol", 32'(o_cfg_rdata), 32'(PL));
    wait_bit("pol_line5", 5, 1'b1, 10);

    // Edge line 7: latch, hold after input falls, ack
    i_irq[7] = 1'b1;
    repeat (10) step();
    i_irq[7] = 1'b0;
    repeat (8) step();
    check("edge7_held", 32'(o_ext[7]), 32'd1);
    i_cfg_sel = 2'd3; #1;
    check("pend7_set", 32'(o_cfg_rdata[7]), 32'd1);
    i_ack = 1'b1; i_ack_id = 5'd7;
    step();
    i_ack = 1'b0;
    check("ack7_pend", 32'(o_cfg_rdata[7]), 32'd0);
    check("ack7_ext_hold", 32'(o_ext[7]), 32'd1);
    step();
    check("ack7_ext_drop", 32'(o_ext[7]), 32'd0);

    // Line 2: ack sampled on the same edge as the rise event
    i_irq[2] = 1'b1;
    repeat (3) step();
    i_ack = 1'b1; i_ack_id = 5'd2;
    step();
    i_ack = 1'b0;
    check("collide_pend", 32'(o_cfg_rdata[2]), 32'd1);
    step();
    check("collide_ext", 32'(o_ext[2]), 32'd1);
    check("pend_only2", 32'(o_cfg_rdata), 32'h4);
    i_ack = 1'b1; i_ack_id = 5'd31;
    step();
    i_ack = 1'b0;
    step();
    check("ack31_pend", 32'(o_cfg_rdata), 32'h4);
    check("ack31_ext", 32'(o_ext), 32'h24);

    // Line 9: mask keeps pending, unmask restores output
    i_irq[9] = 1'b1;
    repeat (4) step();
    i_irq[9] = 1'b0;
    wait_bit("edge9_set", 9, 1'b1, 10);
    cfg_write(2'd0, EN & ~31'h200);
    check("mask9_hold", 32'(o_ext[9]), 32'd1);
    step();
    check("mask9_ext", 32'(o_ext[9]), 32'd0);
    i_cfg_sel = 2'd3; #1;
    check("mask9_pend", 32'(o_cfg_rdata[9]), 32'd1);
    cfg_write(2'd0, EN);
    check("unmask9_hold", 32'(o_ext[9]), 32'd0);
    step();
    check("unmask9_ext", 32'(o_ext[9]), 32'd1);

    // W1C clears only written-1 bits
    cfg_write(2'd3, 31'h200);
    i_cfg_sel = 2'd3; #1;
    check("w1c9_pend", 32'(o_cfg_rdata[9]), 32'd0);
    check("w1c_keep2", 32'(o_cfg_rdata[2]), 32'd1);
    step();
    check("w1c9_ext", 32'(o_ext[9]), 32'd0);

    // Switching line 9 to level mode drops its pending bit
    i_irq[9] = 1'b1;
    repeat (6) step();
    check("pend9_again", 32'(o_cfg_rdata[9]), 32'd1);
    cfg_write(2'd1, MD & ~31'h200);
    i_cfg_sel = 2'd3; #1;
    check("mode0_clr9", 32'(o_cfg_rdata[9]), 32'd0);

    // Asynchronous reset mid-cycle with live state
    #2;
    rst = 1'b0;
    #1;
    check("arst_ext", 32'(o_ext), 32'h0);
    check("arst_pend", 32'(o_cfg_rdata), 32'h0);
    model_reset();
    i_irq = '0;
    @(posedge clk);
    #1;
    rst = 1'b1;

    // Randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      i_irq       = i_irq ^ N'($urandom & $urandom & $urandom);
      i_cfg_we    = ($urandom_range(0, 15) == 0);
      i_cfg_sel   = 2'($urandom);
      i_cfg_wdata = N'($urandom);
      i_ack       = ($urandom_range(0, 3) == 0);
      i_ack_id    = 5'($urandom);
      step();
      check("rnd_rdata", 32'(o_cfg_rdata), 32'(m_rd(i_cfg_sel)));
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
